// File: rtl/uart_reg_cmd_ctrl_pkg.sv
// Shared opcodes, response bytes and FSM state encoding
// for the UART register command sequencer.
package uart_reg_cmd_ctrl_pkg;

   localparam logic [7:0] OP_W  = 8'h57;
   localparam logic [7:0] OP_R  = 8'h52;
   localparam logic [7:0] RSP_K = 8'h4B;
   localparam logic [7:0] RSP_E = 8'h45;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_GET_ADDR = 4'd1,
      ST_GET_DATA = 4'd2,
      ST_EXEC     = 4'd3,
      ST_SEND     = 4'd4,
      ST_WAIT_TX  = 4'd5
   } state_t;

endpackage

// File: rtl/uart_reg_cmd_ctrl_reg_bank.sv
// NREGS x WORDSZ register bank: synchronous write,
// combinational read, register 0 exported for the LEDs.
module uart_reg_cmd_ctrl_reg_bank #(
   parameter int WORDSZ = 8,
   parameter int NREGS  = 4,
   parameter int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [WORDSZ-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [WORDSZ-1:0] o_rdata,
   output logic [WORDSZ-1:0] o_reg0
);

   logic [WORDSZ-1:0] r_regs [NREGS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_regs[i_raddr];
   assign o_reg0  = r_regs[0];

endmodule

// File: rtl/uart_reg_cmd_ctrl.sv
// Framed UART command sequencer: 'W' addr data / 'R' addr
// against a small register bank, 1-byte response on UART TX.
module uart_reg_cmd_ctrl
   import uart_reg_cmd_ctrl_pkg::*;
#(
   parameter int WORDSZ         = 8,
   parameter int NREGS          = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_rx_valid,
   input  logic [WORDSZ-1:0] i_rx_data,
   input  logic              i_tx_busy,
   output logic              o_tx_start,
   output logic [WORDSZ-1:0] o_tx_data,
   output logic [WORDSZ-1:0] o_reg0,
   output logic              o_overrun,
   output logic [3:0]        o_state
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [WORDSZ-1:0] NREGS_W  = WORDSZ'(NREGS);
   localparam logic [WORDSZ-1:0] W_OP_W   = WORDSZ'(OP_W);
   localparam logic [WORDSZ-1:0] W_OP_R   = WORDSZ'(OP_R);
   localparam logic [WORDSZ-1:0] W_RSP_K  = WORDSZ'(RSP_K);
   localparam logic [WORDSZ-1:0] W_RSP_E  = WORDSZ'(RSP_E);

   state_t            r_state;
   state_t            w_next;
   logic              r_is_wr;
   logic [WORDSZ-1:0] r_addr;
   logic [WORDSZ-1:0] r_data;
   logic [WORDSZ-1:0] r_resp;
   logic [TW-1:0]     r_tmo;
   logic              r_first;
   logic              r_ovr;

   logic              w_rx;
   logic              w_is_op;
   logic              w_addr_ok;
   logic [WORDSZ-1:0] w_rdata;
   logic              w_we;
   logic              w_tx_start;
   logic              w_tmo_clr;
   logic              w_tmo_inc;
   logic              w_lat_op;
   logic              w_lat_addr;
   logic              w_lat_data;
   logic              w_set_resp;
   logic [WORDSZ-1:0] w_resp;
   logic              w_ovr_set;

   assign w_rx      = i_rx_valid & i_en;
   assign w_is_op   = (i_rx_data == W_OP_W) || (i_rx_data == W_OP_R);
   // Full-width compare so out-of-range addresses never alias
   assign w_addr_ok = (r_addr < NREGS_W);

   uart_reg_cmd_ctrl_reg_bank #(
      .WORDSZ (WORDSZ),
      .NREGS  (NREGS),
      .AW     (AW)
   ) u_reg_bank (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_we),
      .i_waddr (r_addr[AW-1:0]),
      .i_wdata (r_data),
      .i_raddr (r_addr[AW-1:0]),
      .o_rdata (w_rdata),
      .o_reg0  (o_reg0)
   );

   always_comb begin
      w_next     = r_state;
      w_we       = 1'b0;
      w_tx_start = 1'b0;
      w_tmo_clr  = 1'b0;
      w_tmo_inc  = 1'b0;
      w_lat_op   = 1'b0;
      w_lat_addr = 1'b0;
      w_lat_data = 1'b0;
      w_set_resp = 1'b0;
      w_resp     = r_resp;
      w_ovr_set  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rx) begin
               if (w_is_op) begin
                  w_lat_op  = 1'b1;
                  w_tmo_clr = 1'b1;
                  w_next    = ST_GET_ADDR;
               end else begin
                  w_set_resp = 1'b1;
                  w_resp     = W_RSP_E;
                  w_next     = ST_SEND;
               end
            end
         end
         ST_GET_ADDR, ST_GET_DATA: begin
            // An arriving byte beats a coincident timeout
            if (!i_en) begin
               w_next = ST_IDLE;
            end else if (w_rx) begin
               w_tmo_clr = 1'b1;
               if (r_state == ST_GET_ADDR) begin
                  w_lat_addr = 1'b1;
                  w_next     = r_is_wr ? ST_GET_DATA : ST_EXEC;
               end else begin
                  w_lat_data = 1'b1;
                  w_next     = ST_EXEC;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_next = ST_IDLE;
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         ST_EXEC: begin
            if (!i_en) begin
               w_next = ST_IDLE;
            end else begin
               w_ovr_set  = w_rx;
               w_set_resp = 1'b1;
               w_next     = ST_SEND;
               if (!w_addr_ok) begin
                  w_resp = W_RSP_E;
               end else if (r_is_wr) begin
                  w_we   = 1'b1;
                  w_resp = W_RSP_K;
               end else begin
                  w_resp = w_rdata;
               end
            end
         end
         ST_SEND: begin
            w_ovr_set = w_rx;
            if (!i_tx_busy) begin
               w_tx_start = 1'b1;
               w_next     = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX: begin
            // Transmitter may not raise busy until a cycle after start
            w_ovr_set = w_rx;
            if (!r_first && !i_tx_busy) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_is_wr <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_resp  <= '0;
         r_tmo   <= '0;
         r_first <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_first <= w_tx_start;
         if (w_lat_op) begin
            r_is_wr <= (i_rx_data == W_OP_W);
         end
         if (w_lat_addr) begin
            r_addr <= i_rx_data;
         end
         if (w_lat_data) begin
            r_data <= i_rx_data;
         end
         if (w_set_resp) begin
            r_resp <= w_resp;
         end
         if (w_tmo_clr) begin
            r_tmo <= '0;
         end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + 1'b1;
         end
         if (!i_en) begin
            r_ovr <= 1'b0;
         end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end
      end
   end

   assign o_tx_start = w_tx_start;
   assign o_tx_data  = r_resp;
   assign o_overrun  = r_ovr;
   assign o_state    = r_state;

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Bench for uart_reg_cmd_ctrl: directed plus randomized frames
// checked against a frame-level model of the register bank.
module tb_uart_reg_cmd_ctrl;

   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       model_busy = 1'b0;
   logic       hold = 1'b0;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] reg0;
   logic       overrun;
   logic [3:0] state;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] got_q[$];
   logic [7:0] m_regs[4];

   assign tx_busy = model_busy | hold;

   always #5 clk = ~clk;

   uart_reg_cmd_ctrl #(
      .WORDSZ         (8),
      .NREGS          (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_rx_valid (rx_valid),
      .i_rx_data  (rx_data),
      .i_tx_busy  (tx_busy),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .o_reg0     (reg0),
      .o_overrun  (overrun),
      .o_state    (state)
   );

   // UART transmitter model: records each start, then stays busy a while
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            got_q.push_back(tx_data);
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat ($urandom_range(2, 12)) @(posedge clk);
            #1 model_busy = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nidle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic set_hold(input logic v);
      @(posedge clk);
      #1 hold = v;
      @(negedge clk);
   endtask

   task automatic wait_quiet();
      int t;
      t = 0;
      nidle(2);
      while (tx_busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("busy_bound", 32'(t < 2000), 32'd1);
      nidle(3);
   endtask

   task automatic expect_resp(input string tag, input logic has,
                              input logic [7:0] val);
      int t;
      t = 0;
      if (has) begin
         while (got_q.size() == 0 && t < 1000) begin
            @(negedge clk);
            t++;
         end
         wait_quiet();
         chk({tag, "_txcnt"}, 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) begin
            chk({tag, "_txdata"}, 32'(got_q[0]), 32'(val));
         end
      end else begin
         nidle(20);
         chk({tag, "_notx"}, 32'(got_q.size()), 32'd0);
      end
      chk({tag, "_reg0"}, 32'(reg0), 32'(m_regs[0]));
      got_q.delete();
   endtask

   // Frame-level model: gaps are idle cycles between byte strobes
   task automatic frame(input string tag, input logic [7:0] op,
                        input logic [7:0] a, input logic [7:0] d,
                        input int g1, input int g2);
      logic       has;
      logic [7:0] val;
      has = 1'b0;
      val = 8'h00;
      send_byte(op);
      if (!(op == 8'h57 || op == 8'h52)) begin
         has = 1'b1;
         val = 8'h45;
      end else begin
         nidle(g1);
         if (g1 < TMO) begin
            send_byte(a);
            if (op == 8'h52) begin
               has = 1'b1;
               val = (a < 8'd4) ? m_regs[a[1:0]] : 8'h45;
            end else begin
               nidle(g2);
               if (g2 < TMO) begin
                  send_byte(d);
                  has = 1'b1;
                  if (a < 8'd4) begin
                     m_regs[a[1:0]] = d;
                     val = 8'h4B;
                  end else begin
                     val = 8'h45;
                  end
               end
            end
         end
      end
      expect_resp(tag, has, val);
   endtask

   initial begin
      logic [7:0] op;
      logic [7:0] a;
      int         r;
      int         t;

      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

      nidle(3);
      chk("rst_reg0", 32'(reg0), 32'd0);
      chk("rst_txstart", 32'(tx_start), 32'd0);
      chk("rst_txdata", 32'(tx_data), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      en = 1'b1;
      nidle(2);

      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h41);
      chk("t1_reg0_early", 32'(reg0), 32'h00);
      @(negedge clk);
      chk("t1_reg0_edge2", 32'(reg0), 32'h41);
      chk("t1_txstart", 32'(tx_start), 32'd1);
      chk("t1_txdata", 32'(tx_data), 32'h4B);
      m_regs[0] = 8'h41;
      expect_resp("t1", 1'b1, 8'h4B);

      frame("t2w", 8'h57, 8'h02, 8'h5A, 0, 0);
      frame("t2r", 8'h52, 8'h02, 8'h00, 0, 0);
      frame("t3w5", 8'h57, 8'h05, 8'h11, 0, 0);
      frame("t3bad", 8'h33, 8'h00, 8'h00, 0, 0);
      frame("t3alias", 8'h57, 8'h84, 8'hEE, 1, 2);
      frame("gap99", 8'h57, 8'h03, 8'($urandom), TMO - 1, TMO - 1);
      frame("t4", 8'h57, 8'h01, 8'h77, 0, TMO);
      chk("t4_state", 32'(state), 32'd0);
      frame("t4r", 8'h52, 8'h01, 8'h00, 0, 0);
      frame("t4addr", 8'h52, 8'h00, 8'h00, TMO + 5, 0);

      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            op = 8'h57;
         end else if (r < 8) begin
            op = 8'h52;
         end else begin
            op = 8'($urandom);
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
         end
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                          : 8'($urandom_range(0, 5));
         frame("rnd", op, a, 8'($urandom),
               $urandom_range(0, 8), $urandom_range(0, 8));
      end

      set_hold(1'b1);
      send_byte(8'h52);
      send_byte(8'h00);
      nidle(500);
      chk("t5_held", 32'(got_q.size()), 32'd0);
      send_byte(8'h33);
      nidle(1);
      chk("t5_ovr_set", 32'(overrun), 32'd1);
      set_hold(1'b0);
      expect_resp("t5", 1'b1, m_regs[0]);
      chk("t5_ovr_sticky", 32'(overrun), 32'd1);
      en = 1'b0;
      nidle(1);
      chk("t5_ovr_clr", 32'(overrun), 32'd0);
      en = 1'b1;
      nidle(2);

      send_byte(8'h57);
      send_byte(8'h00);
      en = 1'b0;
      nidle(2);
      en = 1'b1;
      chk("t6_abort_state", 32'(state), 32'd0);
      expect_resp("t6_abort", 1'b0, 8'h00);
      frame("t6w", 8'h57, 8'h00, 8'hA5, 0, 0);

      send_byte(8'h52);
      send_byte(8'h01);
      t = 0;
      while (got_q.size() == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t6_tx_seen", 32'(got_q.size()), 32'd1);
      set_hold(1'b1);
      nidle(2);
      send_byte(8'h33);
      chk("t6_ovr_wait", 32'(overrun), 32'd1);
      chk("t6_reg0_pre", 32'(reg0), 32'hA5);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_reg0", 32'(reg0), 32'd0);
      chk("t6_rst_state", 32'(state), 32'd0);
      chk("t6_rst_txstart", 32'(tx_start), 32'd0);
      chk("t6_rst_txdata", 32'(tx_data), 32'd0);
      chk("t6_rst_ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      nidle(2);
      rst_n = 1'b1;
      set_hold(1'b0);
      wait_quiet();
      got_q.delete();
      frame("post_rst", 8'h52, 8'h00, 8'h00, 0, 0);
      frame("post_rst2", 8'h52, 8'h01, 8'h00, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
